// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: state codes, memory
// commands, instruction fields and one-hot datapath selects.
package cpu_ctrl_pkg;

  localparam logic [4:0] ST_RST   = 5'd0;
  localparam logic [4:0] ST_IF1   = 5'd1;
  localparam logic [4:0] ST_IFW   = 5'd2;
  localparam logic [4:0] ST_UPDPC = 5'd3;
  localparam logic [4:0] ST_DEC   = 5'd4;
  localparam logic [4:0] ST_WIMM  = 5'd5;
  localparam logic [4:0] ST_GETB  = 5'd6;
  localparam logic [4:0] ST_GETA  = 5'd7;
  localparam logic [4:0] ST_EXEC  = 5'd8;
  localparam logic [4:0] ST_WB    = 5'd9;
  localparam logic [4:0] ST_MADR  = 5'd10;
  localparam logic [4:0] ST_LADR  = 5'd11;
  localparam logic [4:0] ST_MRD   = 5'd12;
  localparam logic [4:0] ST_MLD   = 5'd13;
  localparam logic [4:0] ST_WBM   = 5'd14;
  localparam logic [4:0] ST_GRD   = 5'd15;
  localparam logic [4:0] ST_SC    = 5'd16;
  localparam logic [4:0] ST_MWR   = 5'd17;
  localparam logic [4:0] ST_BR    = 5'd18;
  localparam logic [4:0] ST_BLNK  = 5'd19;
  localparam logic [4:0] ST_BLXL  = 5'd20;
  localparam logic [4:0] ST_JMP   = 5'd21;
  localparam logic [4:0] ST_HALT  = 5'd22;
  localparam logic [4:0] ST_FAULT = 5'd23;

  localparam logic [1:0] MC_NONE  = 2'b00;
  localparam logic [1:0] MC_READ  = 2'b11;
  localparam logic [1:0] MC_WRITE = 2'b10;

  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_BL   = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b00;
  localparam logic [1:0] OP_BX   = 2'b00;
  localparam logic [1:0] OP_BLX  = 2'b10;
  localparam logic [1:0] OP_BL   = 2'b11;

  localparam logic [2:0] CD_AL = 3'b000;
  localparam logic [2:0] CD_EQ = 3'b001;
  localparam logic [2:0] CD_NE = 3'b010;
  localparam logic [2:0] CD_LT = 3'b011;
  localparam logic [2:0] CD_LE = 3'b100;

  localparam logic [2:0] NS_RN = 3'b001;
  localparam logic [2:0] NS_RD = 3'b010;
  localparam logic [2:0] NS_RM = 3'b100;

  localparam logic [3:0] VS_C     = 4'b0001;
  localparam logic [3:0] VS_PC    = 4'b0010;
  localparam logic [3:0] VS_IMM   = 4'b0100;
  localparam logic [3:0] VS_MDATA = 4'b1000;

  localparam logic [2:0] PC_INC = 3'b001;
  localparam logic [2:0] PC_REG = 3'b010;
  localparam logic [2:0] PC_REL = 3'b100;

  function automatic logic cond_legal(input logic [2:0] c);
    return c <= CD_LE;
  endfunction

  function automatic logic cond_taken(input logic [2:0] c, input logic z,
                                      input logic n, input logic v);
    logic w_t;
    case (c)
      CD_AL:   w_t = 1'b1;
      CD_EQ:   w_t = z;
      CD_NE:   w_t = ~z;
      CD_LT:   w_t = n ^ v;
      CD_LE:   w_t = (n ^ v) | z;
      default: w_t = 1'b0;
    endcase
    return w_t;
  endfunction

endpackage

// File: rtl/cpu_ctrl_ws_mem_wait_timer.sv
// Wait-state counter for memory accesses: signals completion after a fixed
// latency or on mem_ready, and a timeout when the ready handshake stalls.
module mem_wait_timer #(
  parameter int MEM_LAT   = 1,
  parameter int USE_READY = 0,
  parameter int TIMEOUT   = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic mem_ready,
  output logic done,
  output logic timeout
);

  localparam logic [4:0] LAT_LAST = 5'(MEM_LAT - 1);
  localparam logic [4:0] TO_LAST  = 5'(TIMEOUT - 1);

  logic [4:0] r_cnt;

  // Saturates so a long ready stall never wraps back into a false completion.
  always_ff @(posedge clk) begin
    if (reset || clear)
      r_cnt <= '0;
    else if (enable && (r_cnt != 5'h1f))
      r_cnt <= r_cnt + 5'd1;
  end

  always_comb begin
    done    = 1'b0;
    timeout = 1'b0;
    if (USE_READY != 0) begin
      done    = enable & mem_ready;
      timeout = enable & ~mem_ready & (r_cnt >= TO_LAST);
    end else begin
      done    = enable & (r_cnt == LAT_LAST);
    end
  end

endmodule

// File: rtl/cpu_ctrl_ws.sv
// Multi-cycle control FSM for the 16-bit CPU with configurable memory latency,
// optional ready handshake, timeout and illegal-encoding faults.
module cpu_ctrl_ws
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int USE_READY = 0,
  parameter int TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       mem_ready,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       write,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [2:0] pc_sel,
  output logic [1:0] mem_cmd,
  output logic       halt,
  output logic       fault,
  output logic [4:0] state_o
);

  logic [4:0] r_state;
  logic [4:0] w_next;
  logic       w_in_wait;
  logic       w_done;
  logic       w_tmo;

  assign w_in_wait = (r_state == ST_IFW) || (r_state == ST_MRD) || (r_state == ST_MWR);
  assign state_o   = r_state;

  // Held clear outside wait states, so every wait starts counting from zero.
  mem_wait_timer #(
    .MEM_LAT  (MEM_LAT),
    .USE_READY(USE_READY),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (~w_in_wait),
    .enable   (w_in_wait),
    .mem_ready(mem_ready),
    .done     (w_done),
    .timeout  (w_tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:   w_next = ST_IF1;
      ST_IF1:   w_next = ST_IFW;
      ST_IFW:   if (w_tmo) w_next = ST_FAULT; else if (w_done) w_next = ST_UPDPC;
      ST_MRD:   if (w_tmo) w_next = ST_FAULT; else if (w_done) w_next = ST_MLD;
      ST_MWR:   if (w_tmo) w_next = ST_FAULT; else if (w_done) w_next = ST_IF1;
      ST_UPDPC: w_next = ST_DEC;
      ST_DEC: begin
        case (opcode)
          OPC_MOV:  w_next = (op == OP_MOVI) ? ST_WIMM :
                             (op == OP_MOVR) ? ST_GETB : ST_FAULT;
          OPC_ALU:  w_next = ST_GETB;
          OPC_LDR,
          OPC_STR:  w_next = (op == OP_MEM) ? ST_GETA : ST_FAULT;
          OPC_B:    w_next = (op == 2'b00 && cond_legal(cond)) ? ST_BR : ST_FAULT;
          OPC_BL:   w_next = (op == OP_BL)  ? ST_BLNK :
                             (op == OP_BX)  ? ST_GRD  :
                             (op == OP_BLX) ? ST_BLXL : ST_FAULT;
          OPC_HALT: w_next = ST_HALT;
          default:  w_next = ST_FAULT;
        endcase
      end
      ST_WIMM:  w_next = ST_IF1;
      ST_GETB:  w_next = ST_GETA;
      ST_GETA:  w_next = (opcode == OPC_LDR || opcode == OPC_STR) ? ST_MADR : ST_EXEC;
      ST_EXEC:  w_next = (opcode == OPC_ALU && op == OP_CMP) ? ST_IF1 : ST_WB;
      ST_WB:    w_next = ST_IF1;
      ST_MADR:  w_next = ST_LADR;
      ST_LADR:  w_next = (opcode == OPC_LDR) ? ST_MRD : ST_GRD;
      ST_MLD:   w_next = ST_WBM;
      ST_WBM:   w_next = ST_IF1;
      ST_GRD:   w_next = ST_SC;
      ST_SC:    w_next = (opcode == OPC_BL) ? ST_JMP : ST_MWR;
      ST_BR:    w_next = ST_IF1;
      ST_BLNK:  w_next = ST_IF1;
      ST_BLXL:  w_next = ST_GRD;
      ST_JMP:   w_next = ST_IF1;
      ST_HALT:  w_next = ST_HALT;
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_FAULT;
    endcase
  end

  always_comb begin
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    nsel      = NS_RN;
    vsel      = VS_C;
    write     = 1'b0;
    reset_pc  = 1'b0;
    load_pc   = 1'b0;
    load_ir   = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    pc_sel    = PC_INC;
    mem_cmd   = MC_NONE;
    halt      = 1'b0;
    fault     = 1'b0;
    case (r_state)
      ST_RST:   begin reset_pc = 1'b1; load_pc = 1'b1; end
      ST_IF1:   begin addr_sel = 1'b1; mem_cmd = MC_READ; end
      ST_IFW:   begin addr_sel = 1'b1; mem_cmd = MC_READ; load_ir = w_done; end
      ST_UPDPC: load_pc = 1'b1;
      ST_WIMM:  begin write = 1'b1; vsel = VS_IMM; end
      ST_GETB:  begin loadb = 1'b1; nsel = NS_RM; end
      ST_GETA:  loada = (opcode != OPC_MOV);
      ST_EXEC: begin
        asel = (opcode == OPC_MOV);
        if (opcode == OPC_ALU && op == OP_CMP) loads = 1'b1;
        else                                    loadc = 1'b1;
      end
      ST_WB:    begin write = 1'b1; nsel = NS_RD; end
      ST_MADR:  begin bsel = 1'b1; loadc = 1'b1; end
      ST_LADR:  load_addr = 1'b1;
      ST_MRD:   mem_cmd = MC_READ;
      ST_WBM:   begin write = 1'b1; nsel = NS_RD; vsel = VS_MDATA; end
      ST_GRD:   begin loadb = 1'b1; nsel = NS_RD; end
      ST_SC:    begin asel = 1'b1; loadc = 1'b1; end
      ST_MWR:   mem_cmd = MC_WRITE;
      ST_BR:    begin load_pc = cond_taken(cond, Z, N, V); pc_sel = PC_REL; end
      ST_BLNK:  begin write = 1'b1; vsel = VS_PC; load_pc = 1'b1; pc_sel = PC_REL; end
      ST_BLXL:  begin write = 1'b1; vsel = VS_PC; end
      ST_JMP:   begin load_pc = 1'b1; pc_sel = PC_REG; end
      ST_HALT:  halt = 1'b1;
      ST_FAULT: fault = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_ws.sv
// Directed vector bench for cpu_ctrl_ws: three instances (MEM_LAT=1, MEM_LAT=3,
// ready handshake) stepped cycle by cycle against hand-built expected strobes.
module tb_cpu_ctrl_ws;
  import cpu_ctrl_pkg::*;

  localparam logic [13:0] S_LA = 14'h2000, S_LB = 14'h1000, S_LC = 14'h0800, S_LS = 14'h0400;
  localparam logic [13:0] S_AS = 14'h0200, S_BS = 14'h0100, S_WR = 14'h0080, S_RP = 14'h0040;
  localparam logic [13:0] S_LP = 14'h0020, S_IR = 14'h0010, S_AD = 14'h0008, S_LD = 14'h0004;
  localparam logic [13:0] S_HT = 14'h0002, S_FT = 14'h0001, S_0 = 14'h0000;
  localparam logic [2:0] N1 = 3'b001, N2 = 3'b010, N4 = 3'b100;
  localparam logic [3:0] V1 = 4'b0001, V2 = 4'b0010, V4 = 4'b0100, V8 = 4'b1000;
  localparam logic [2:0] P1 = 3'b001, P2 = 3'b010, P4 = 3'b100;
  localparam logic [1:0] MN = 2'b00, MR = 2'b11, MW = 2'b10;

  typedef struct {
    int          k;
    logic        r;
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [2:0]  cond;
    logic        rdy;
    logic [30:0] want;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst, Zf, Nf, Vf, rdy;
  logic [2:0][2:0] opc, cnd;
  logic [2:0][1:0] opf;
  wire  [2:0]      la, lb, lc, ls, asl, bsl, wr, rp, lp, li, ad, ldad, ht, ft;
  wire  [2:0][2:0] ns, pcs;
  wire  [2:0][3:0] vs;
  wire  [2:0][1:0] mc;
  wire  [2:0][4:0] st;

  cpu_ctrl_ws #(.MEM_LAT(1), .USE_READY(0), .TIMEOUT(15)) u0 (
    .clk(clk), .reset(rst[0]), .opcode(opc[0]), .op(opf[0]), .cond(cnd[0]),
    .Z(Zf[0]), .N(Nf[0]), .V(Vf[0]), .mem_ready(rdy[0]),
    .loada(la[0]), .loadb(lb[0]), .loadc(lc[0]), .loads(ls[0]), .asel(asl[0]), .bsel(bsl[0]),
    .nsel(ns[0]), .vsel(vs[0]), .write(wr[0]), .reset_pc(rp[0]), .load_pc(lp[0]),
    .load_ir(li[0]), .addr_sel(ad[0]), .load_addr(ldad[0]), .pc_sel(pcs[0]),
    .mem_cmd(mc[0]), .halt(ht[0]), .fault(ft[0]), .state_o(st[0]));

  cpu_ctrl_ws #(.MEM_LAT(3), .USE_READY(0), .TIMEOUT(15)) u1 (
    .clk(clk), .reset(rst[1]), .opcode(opc[1]), .op(opf[1]), .cond(cnd[1]),
    .Z(Zf[1]), .N(Nf[1]), .V(Vf[1]), .mem_ready(rdy[1]),
    .loada(la[1]), .loadb(lb[1]), .loadc(lc[1]), .loads(ls[1]), .asel(asl[1]), .bsel(bsl[1]),
    .nsel(ns[1]), .vsel(vs[1]), .write(wr[1]), .reset_pc(rp[1]), .load_pc(lp[1]),
    .load_ir(li[1]), .addr_sel(ad[1]), .load_addr(ldad[1]), .pc_sel(pcs[1]),
    .mem_cmd(mc[1]), .halt(ht[1]), .fault(ft[1]), .state_o(st[1]));

  cpu_ctrl_ws #(.MEM_LAT(1), .USE_READY(1), .TIMEOUT(15)) u2 (
    .clk(clk), .reset(rst[2]), .opcode(opc[2]), .op(opf[2]), .cond(cnd[2]),
    .Z(Zf[2]), .N(Nf[2]), .V(Vf[2]), .mem_ready(rdy[2]),
    .loada(la[2]), .loadb(lb[2]), .loadc(lc[2]), .loads(ls[2]), .asel(asl[2]), .bsel(bsl[2]),
    .nsel(ns[2]), .vsel(vs[2]), .write(wr[2]), .reset_pc(rp[2]), .load_pc(lp[2]),
    .load_ir(li[2]), .addr_sel(ad[2]), .load_addr(ldad[2]), .pc_sel(pcs[2]),
    .mem_cmd(mc[2]), .halt(ht[2]), .fault(ft[2]), .state_o(st[2]));

  int   total = 0;
  int   bad   = 0;
  vec_t tv[$];
  int         cur_k;
  logic [2:0] cur_opc, cur_cond;
  logic [1:0] cur_op;
  logic       cur_rdy;

  function automatic logic [30:0] snap(input int k);
    return {st[k], la[k], lb[k], lc[k], ls[k], asl[k], bsl[k], wr[k], rp[k], lp[k],
            li[k], ad[k], ldad[k], ht[k], ft[k], ns[k], vs[k], pcs[k], mc[k]};
  endfunction

  task automatic chk(input string nm, input logic [30:0] got, input logic [30:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic add(input logic [4:0] s, input logic [13:0] b, input logic [2:0] n,
                     input logic [3:0] v, input logic [2:0] p, input logic [1:0] m,
                     input logic r);
    vec_t t;
    t.k = cur_k; t.r = r; t.opc = cur_opc; t.op = cur_op; t.cond = cur_cond;
    t.rdy = cur_rdy; t.want = {s, b, n, v, p, m};
    tv.push_back(t);
  endtask

  task automatic add0(input logic [4:0] s, input logic [13:0] b);
    add(s, b, N1, V1, P1, MN, 1'b0);
  endtask

  task automatic instr(input int k, input logic [2:0] o, input logic [1:0] p, input logic [2:0] c);
    cur_k = k; cur_opc = o; cur_op = p; cur_cond = c;
  endtask

  // Fetch sequence: IF1, lat IFW cycles with load_ir on the last, UPDPC, DEC.
  task automatic fetch(input int lat);
    add(ST_IF1, S_AD, N1, V1, P1, MR, 1'b0);
    for (int i = 0; i < lat - 1; i++) add(ST_IFW, S_AD, N1, V1, P1, MR, 1'b0);
    add(ST_IFW, S_AD | S_IR, N1, V1, P1, MR, 1'b0);
    add0(ST_UPDPC, S_LP);
    add0(ST_DEC, S_0);
  endtask

  task automatic build();
    cur_rdy = 1'b0;
    // MEM_LAT=1 instance
    instr(0, 3'b110, 2'b10, 3'b000);
    add0(ST_RST, S_RP | S_LP);
    fetch(1); add(ST_WIMM, S_WR, N1, V4, P1, MN, 1'b0);
    instr(0, 3'b101, 2'b00, 3'b000);
    fetch(1); add(ST_GETB, S_LB, N4, V1, P1, MN, 1'b0); add0(ST_GETA, S_LA);
    add0(ST_EXEC, S_LC); add(ST_WB, S_WR, N2, V1, P1, MN, 1'b0);
    instr(0, 3'b101, 2'b01, 3'b000);
    fetch(1); add(ST_GETB, S_LB, N4, V1, P1, MN, 1'b0); add0(ST_GETA, S_LA); add0(ST_EXEC, S_LS);
    instr(0, 3'b110, 2'b00, 3'b000);
    fetch(1); add(ST_GETB, S_LB, N4, V1, P1, MN, 1'b0); add0(ST_GETA, S_0);
    add0(ST_EXEC, S_AS | S_LC); add(ST_WB, S_WR, N2, V1, P1, MN, 1'b0);
    instr(0, 3'b001, 2'b00, 3'b100);
    fetch(1); add(ST_BR, S_LP, N1, V1, P4, MN, 1'b0);
    instr(0, 3'b001, 2'b00, 3'b001);
    fetch(1); add(ST_BR, S_0, N1, V1, P4, MN, 1'b0);
    instr(0, 3'b010, 2'b11, 3'b000);
    fetch(1); add(ST_BLNK, S_WR | S_LP, N1, V2, P4, MN, 1'b0);
    instr(0, 3'b010, 2'b10, 3'b000);
    fetch(1); add(ST_BLXL, S_WR, N1, V2, P1, MN, 1'b0); add(ST_GRD, S_LB, N2, V1, P1, MN, 1'b0);
    add0(ST_SC, S_AS | S_LC); add(ST_JMP, S_LP, N1, V1, P2, MN, 1'b0);
    instr(0, 3'b010, 2'b00, 3'b000);
    fetch(1); add(ST_GRD, S_LB, N2, V1, P1, MN, 1'b0);
    add0(ST_SC, S_AS | S_LC); add(ST_JMP, S_LP, N1, V1, P2, MN, 1'b0);
    instr(0, 3'b100, 2'b00, 3'b000);
    fetch(1); add0(ST_GETA, S_LA); add0(ST_MADR, S_BS | S_LC); add0(ST_LADR, S_LD);
    add(ST_GRD, S_LB, N2, V1, P1, MN, 1'b0); add0(ST_SC, S_AS | S_LC);
    add(ST_MWR, S_0, N1, V1, P1, MW, 1'b0);
    instr(0, 3'b001, 2'b00, 3'b101);
    fetch(1); add0(ST_FAULT, S_FT); add0(ST_FAULT, S_FT); add(ST_FAULT, S_FT, N1, V1, P1, MN, 1'b1);
    instr(0, 3'b000, 2'b00, 3'b000);
    add0(ST_RST, S_RP | S_LP);
    fetch(1); add(ST_FAULT, S_FT, N1, V1, P1, MN, 1'b1);
    instr(0, 3'b111, 2'b01, 3'b000);
    add0(ST_RST, S_RP | S_LP);
    fetch(1); add0(ST_HALT, S_HT);
    // MEM_LAT=3 instance: LDR, then STR interrupted by reset in MWR
    instr(1, 3'b011, 2'b00, 3'b000);
    add0(ST_RST, S_RP | S_LP);
    fetch(3); add0(ST_GETA, S_LA); add0(ST_MADR, S_BS | S_LC); add0(ST_LADR, S_LD);
    for (int i = 0; i < 3; i++) add(ST_MRD, S_0, N1, V1, P1, MR, 1'b0);
    add0(ST_MLD, S_0); add(ST_WBM, S_WR, N2, V8, P1, MN, 1'b0);
    instr(1, 3'b100, 2'b00, 3'b000);
    fetch(3); add0(ST_GETA, S_LA); add0(ST_MADR, S_BS | S_LC); add0(ST_LADR, S_LD);
    add(ST_GRD, S_LB, N2, V1, P1, MN, 1'b0); add0(ST_SC, S_AS | S_LC);
    add(ST_MWR, S_0, N1, V1, P1, MW, 1'b0); add(ST_MWR, S_0, N1, V1, P1, MW, 1'b1);
    add0(ST_RST, S_RP | S_LP); add(ST_IF1, S_AD, N1, V1, P1, MR, 1'b0);
    // Ready-handshake instance: delayed ready, stray ready, then timeout
    instr(2, 3'b001, 2'b00, 3'b000);
    add0(ST_RST, S_RP | S_LP);
    cur_rdy = 1'b1; add(ST_IF1, S_AD, N1, V1, P1, MR, 1'b0);
    cur_rdy = 1'b0;
    for (int i = 0; i < 4; i++) add(ST_IFW, S_AD, N1, V1, P1, MR, 1'b0);
    cur_rdy = 1'b1; add(ST_IFW, S_AD | S_IR, N1, V1, P1, MR, 1'b0);
    add0(ST_UPDPC, S_LP); add0(ST_DEC, S_0); add(ST_BR, S_LP, N1, V1, P4, MN, 1'b0);
    cur_rdy = 1'b0; add(ST_IF1, S_AD, N1, V1, P1, MR, 1'b0);
    for (int i = 0; i < 15; i++) add(ST_IFW, S_AD, N1, V1, P1, MR, 1'b0);
    add0(ST_FAULT, S_FT); add(ST_FAULT, S_FT, N1, V1, P1, MN, 1'b1);
    add0(ST_RST, S_RP | S_LP); add(ST_IF1, S_AD, N1, V1, P1, MR, 1'b0);
  endtask

  initial begin
    int k, n, cyc, mrd;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, cyc, mrd;
    rst = '1; rdy = '0; opc = '0; opf = '0; cnd = '0;
    Zf = 3'b000; Nf = 3'b111; Vf = 3'b000;
    build();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tv.size(); i++) begin
      k = tv[i].k;
      rst[k] = tv[i].r; opc[k] = tv[i].opc; opf[k] = tv[i].op;
      cnd[k] = tv[i].cond; rdy[k] = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d_dut%0d", i, k), snap(k), tv[i].want);
      @(posedge clk); #1;
    end

    // HALT is absorbing with every strobe inactive
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halt_hold%0d", i), snap(0), {ST_HALT, S_HT, N1, V1, P1, MN});
      @(posedge clk); #1;
    end

    // LDR with MEM_LAT=3: IF1-to-IF1 span and READ cycles in MRD
    rst[1] = 1'b1; opc[1] = 3'b011; opf[1] = 2'b00;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    n = 0;
    while (st[1] != ST_IF1 && n < 10) begin @(posedge clk); #1; n++; end
    cyc = 0; mrd = 0;
    do begin
      if (st[1] == ST_MRD && mc[1] == MR) mrd++;
      @(posedge clk); #1;
      cyc++;
    end while (st[1] != ST_IF1 && cyc < 60);
    chk("ldr_cycles", 31'(cyc), 31'(14));
    chk("ldr_mrd_reads", 31'(mrd), 31'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_ws.md
Name: cpu_ctrl_ws

Overview:
Multi-cycle control FSM for the 16-bit CPU. It decodes opcode/op/cond and drives every datapath, PC and memory strobe. It generalises the fixed single-cycle memory sequencing to a configurable-latency memory with an optional ready handshake, and adds a timeout fault, fault on illegal encodings, and a complete condition set (B, BEQ, BNE, BLT, BLE). It sits between the instruction register/status flags and the datapath, PC, address register and RAM.

Parameters:
MEM_LAT, 1, memory access cycles when USE_READY=0; legal range 1..15.
USE_READY, 0, 1 = an access completes on mem_ready; 0 = it completes after MEM_LAT cycles.
TIMEOUT, 15, maximum wait cycles in any memory-wait state before FAULT (applies only when USE_READY=1).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; forces RST on the next edge
opcode  in  3  instruction register [15:13]
op  in  2  instruction register [12:11]
cond  in  3  instruction register [10:8]
Z, N, V  in  1 each  status flags
mem_ready  in  1  memory completion; ignored when USE_READY=0
loada, loadb, loadc, loads  out  1 each  datapath register loads
asel, bsel  out  1 each  ALU source selects
nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm
vsel  out  4  one-hot writeback select: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata
write  out  1  register file write
reset_pc, load_pc, load_ir, addr_sel, load_addr  out  1 each
pc_sel  out  3  one-hot: 001 PC+1, 010 C (BX/BLX), 100 PC+sximm8
mem_cmd  out  2  00 NONE, 11 READ, 10 WRITE
halt  out  1  high in HALT
fault  out  1  high in FAULT
state_o  out  5  current state, for debug

Behaviour:
- Default for every output in every state: 0, with nsel=001, vsel=0001, pc_sel=001 and mem_cmd=NONE. There are no x outputs, including after reset.
- RST: reset_pc=1, load_pc=1. Next state IF1.
- IF1: addr_sel=1, mem_cmd=READ. Next state IFW.
- IFW: addr_sel=1, mem_cmd=READ, held. When the access completes, load_ir=1 on that same cycle and the FSM goes to UPDPC. Completion means wait count = MEM_LAT-1 (USE_READY=0) or mem_ready=1 (USE_READY=1).
- UPDPC: load_pc=1, pc_sel=001. Next state DEC.
- DEC, by instruction:
  - MOV imm (110/10): WIMM, which writes Rn with nsel=001 and vsel=0100.
  - MOV reg (110/00) and ALU ops (101/xx): GETB (loadb, nsel=100), then GETA (loada, nsel=001).
    - MOV reg skips the GETA load and sets asel=1 in EXEC.
    - EXEC: loadc=1, or for CMP (101/01) loads=1 and return to IF1.
    - WB: write=1, nsel=010, vsel=0001.
  - LDR (011/00) and STR (100/00): GETA, then MADR (asel=0, bsel=1, loadc=1), then LADR (load_addr=1).
    - LDR: MRD (mem_cmd=READ, addr_sel=0) until completion, then WBM (write=1, nsel=010, vsel=1000).
    - STR: GRD (loadb, nsel=010), then SC (asel=1, loadc=1), then MWR (mem_cmd=WRITE) until completion.
  - B (001/00): BR. load_pc equals the condition result, pc_sel=100, then IF1. Conditions:
    - cond 000: always.
    - cond 001: Z.
    - cond 010: !Z.
    - cond 011: N!=V.
    - cond 100: (N!=V)|Z.
    - Other cond values go to FAULT.
  - BL (010/11): BLNK. write=1, nsel=001, vsel=0010, load_pc=1, pc_sel=100, then IF1.
  - BX (010/00): GRD, then SC, then JMP (load_pc=1, pc_sel=010), then IF1.
  - BLX (010/10): BLNK-style link write without load_pc, then GRD, SC, JMP.
  - HALT (111/xx): HALT.
  - Any other encoding: FAULT.
- HALT and FAULT are absorbing states; only reset exits them.
- Wait counter:
  - Clears on entry to IFW, MRD and MWR, and increments while the FSM stays in one of them.
  - If USE_READY=1 and the count reaches TIMEOUT without mem_ready, the next state is FAULT and mem_cmd drops to NONE.
  - mem_ready outside a wait state is ignored.
- Reset mid-access: RST on the next edge, counter cleared, mem_cmd=NONE in RST.
- Cycle counts with USE_READY=0, measured from IF1 to the next IF1:
  - ADD: 7 + MEM_LAT.
  - LDR: 8 + 2*MEM_LAT.

Decomposition:
- Package cpu_ctrl_pkg: 5-bit state encodings, mem_cmd codes, opcode/op constants, cond codes, one-hot nsel/vsel/pc_sel constants.
- One sub-module, mem_wait_timer:
  - Inputs: clear, enable, mem_ready.
  - Outputs: done, timeout.
  - Parameters: MEM_LAT, USE_READY, TIMEOUT.

Test Plan:
- MEM_LAT=1, USE_READY=0: reset, then MOV R0,#5; ADD R1,R0,R0 -> R1=10; ADD takes 8 cycles from IF1 to IF1; load_ir is high exactly once per instruction.
- MEM_LAT=3: LDR R2,[R0] with mem[5]=0x1234 -> R2=0x1234; MRD holds mem_cmd=READ for 3 cycles; total 14 cycles.
- USE_READY=1: mem_ready delayed 4 cycles -> IFW lasts 5 cycles. mem_ready never asserted -> fault=1 after 15 wait cycles; reset returns the FSM to RST and then IF1.
- Flags Z=0, N=1, V=0: BLE -> taken, load_pc=1 with pc_sel=100; BEQ -> not taken; cond=101 -> fault=1.
- BLX R3 with PC=0x10 and R3=0x40 -> R7=0x10, next fetch address 0x40. HALT -> halt=1 held for 20 cycles with no strobes active.
- Assert reset during MWR -> no further WRITE command, state_o=RST one cycle later.
